// File: rtl/clock_display_pkg.sv
// Shared constants and types for the multiplexed clock display scanner.
package clock_display_pkg;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef logic [1:0] digit_idx_t;

endpackage

// File: rtl/clock_display_scanner_if.sv
// Time digits in, multiplexed 7-segment drive out.
interface clock_display_scanner_if;

  logic       enable;
  logic       blank_lead_zero;
  logic [1:0] time_ms_hr;
  logic [3:0] time_ls_hr;
  logic [2:0] time_ms_min;
  logic [3:0] time_ls_min;
  logic [6:0] seg;
  logic [3:0] an;
  logic       colon;
  logic       frame_done;

  modport master (
    output enable, blank_lead_zero, time_ms_hr, time_ls_hr, time_ms_min, time_ls_min,
    input  seg, an, colon, frame_done
  );

  modport slave (
    input  enable, blank_lead_zero, time_ms_hr, time_ls_hr, time_ms_min, time_ls_min,
    output seg, an, colon, frame_done
  );

endinterface

// File: rtl/bcd_to_7seg.sv
// Combinational BCD to 7-segment decoder; non-decimal codes show a dash.
module bcd_to_7seg
  import clock_display_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_DASH;
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/clock_display_scanner.sv
// Scans a frame-snapshotted HH:MM onto a 4-digit common-cathode display with a blinking colon.
module clock_display_scanner
  import clock_display_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int BLINK_FRAMES = 125
) (
  input logic                     clock,
  input logic                     reset,
  clock_display_scanner_if.slave  disp
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [PW-1:0] presc_q, presc_d;
  digit_idx_t    idx_q, idx_d;
  logic [BW-1:0] blink_q, blink_d;
  logic          colon_state_q, colon_state_d;
  logic          load_pending_q, load_pending_d;
  logic [3:0]    shadow_q [4];
  logic [3:0]    shadow_d [4];
  logic [6:0]    seg_q, seg_d;
  logic [3:0]    an_q, an_d;
  logic          colon_q, colon_d;
  logic          frame_done_q, frame_done_d;

  logic          tick;
  logic          wrap;
  logic [6:0]    dec_seg;

  assign tick = disp.enable && (presc_q == PW'(SCAN_DIV - 1));
  assign wrap = tick && (idx_q == 2'd3);

  bcd_to_7seg u_dec (
    .bcd_i (shadow_q[idx_q]),
    .seg_o (dec_seg)
  );

  always_comb begin
    presc_d        = presc_q;
    idx_d          = idx_q;
    blink_d        = blink_q;
    colon_state_d  = colon_state_q;
    load_pending_d = load_pending_q;
    shadow_d       = shadow_q;
    frame_done_d   = wrap;
    seg_d          = SEG_BLANK;
    an_d           = 4'b0000;
    colon_d        = 1'b0;

    if (disp.enable) begin
      presc_d = tick ? '0 : presc_q + 1'b1;
      if (tick) idx_d = idx_q + 2'd1;

      if (wrap) begin
        if (blink_q == BW'(BLINK_FRAMES - 1)) begin
          blink_d       = '0;
          colon_state_d = ~colon_state_q;
        end else begin
          blink_d = blink_q + 1'b1;
        end
      end

      // Snapshot only at frame boundaries so a frame never mixes old and new digits.
      if (load_pending_q || wrap) begin
        shadow_d[0]    = disp.time_ls_min;
        shadow_d[1]    = {1'b0, disp.time_ms_min};
        shadow_d[2]    = disp.time_ls_hr;
        shadow_d[3]    = {2'b00, disp.time_ms_hr};
        load_pending_d = 1'b0;
      end

      an_d    = 4'b0001 << idx_q;
      seg_d   = (idx_q == 2'd3 && disp.blank_lead_zero && shadow_q[3] == 4'd0) ? SEG_BLANK : dec_seg;
      colon_d = colon_state_q;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      presc_q        <= '0;
      idx_q          <= '0;
      blink_q        <= '0;
      colon_state_q  <= 1'b0;
      load_pending_q <= 1'b1;
      for (int i = 0; i < 4; i++) shadow_q[i] <= 4'd0;
      seg_q          <= SEG_BLANK;
      an_q           <= 4'b0000;
      colon_q        <= 1'b0;
      frame_done_q   <= 1'b0;
    end else begin
      presc_q        <= presc_d;
      idx_q          <= idx_d;
      blink_q        <= blink_d;
      colon_state_q  <= colon_state_d;
      load_pending_q <= load_pending_d;
      shadow_q       <= shadow_d;
      seg_q          <= seg_d;
      an_q           <= an_d;
      colon_q        <= colon_d;
      frame_done_q   <= frame_done_d;
    end
  end

  assign disp.seg        = seg_q;
  assign disp.an         = an_q;
  assign disp.colon      = colon_q;
  assign disp.frame_done = frame_done_q;

endmodule

// File: tb/tb_clock_display_scanner.sv
// Directed bench for clock_display_scanner with SCAN_DIV=4, BLINK_FRAMES=2.
module tb_clock_display_scanner;

  logic clock;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   fd_cnt;

  clock_display_scanner_if dif ();

  clock_display_scanner #(
    .SCAN_DIV     (4),
    .BLINK_FRAMES (2)
  ) dut (
    .clock (clock),
    .reset (reset),
    .disp  (dif)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $display("FAIL %s at cycle %0d: observed=%0h expected=%0h", tag, cyc, obs, exp);
      $error("%s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic adv(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
      cyc++;
    end
  endtask

  task automatic goto_cyc(input int n);
    if (n > cyc) adv(n - cyc);
  endtask

  task automatic set_time(input logic [1:0] mh, input logic [3:0] lh,
                          input logic [2:0] mm, input logic [3:0] lm);
    dif.time_ms_hr  = mh;
    dif.time_ls_hr  = lh;
    dif.time_ms_min = mm;
    dif.time_ls_min = lm;
  endtask

  initial begin
    reset               = 1'b0;
    dif.enable          = 1'b1;
    dif.blank_lead_zero = 1'b0;
    set_time(2'd1, 4'd2, 3'd3, 4'd4);

    // reset state
    repeat (3) begin @(posedge clock); #1; end
    chk("rst_an",    32'(dif.an),         32'h0);
    chk("rst_seg",   32'(dif.seg),        32'h0);
    chk("rst_colon", 32'(dif.colon),      32'h0);
    chk("rst_fd",    32'(dif.frame_done), 32'h0);

    reset = 1'b1;
    cyc   = 0;

    // first frame of 12:34
    goto_cyc(1);  chk("f1_an0_first", 32'(dif.an), 32'h1);
    goto_cyc(2);  chk("f1_an0", 32'(dif.an), 32'h1); chk("f1_seg0", 32'(dif.seg), 32'h66);
    goto_cyc(5);  chk("f1_an1", 32'(dif.an), 32'h2); chk("f1_seg1", 32'(dif.seg), 32'h4F);
    goto_cyc(8);  chk("f1_an1_end", 32'(dif.an), 32'h2);
    goto_cyc(9);  chk("f1_an2", 32'(dif.an), 32'h4); chk("f1_seg2", 32'(dif.seg), 32'h5B);
    set_time(2'd1, 4'd2, 3'd3, 4'd5);
    goto_cyc(13); chk("f1_an3", 32'(dif.an), 32'h8); chk("f1_seg3", 32'(dif.seg), 32'h06);
    chk("f1_fd_low", 32'(dif.frame_done), 32'h0);
    goto_cyc(16); chk("f1_fd", 32'(dif.frame_done), 32'h1);

    // second frame shows the mid-frame change; count frame_done pulses over two frames
    fd_cnt = 0;
    repeat (32) begin
      adv(1);
      if (dif.frame_done) fd_cnt++;
      if (cyc == 17) begin
        chk("f2_an0",  32'(dif.an),  32'h1);
        chk("f2_seg0", 32'(dif.seg), 32'h6D);
      end
      if (cyc == 32) chk("colon_pre",  32'(dif.colon), 32'h0);
      if (cyc == 33) chk("colon_on",   32'(dif.colon), 32'h1);
    end
    chk("fd_count", 32'(fd_cnt), 32'd2);
    goto_cyc(64); chk("colon_hold", 32'(dif.colon), 32'h1);
    goto_cyc(65); chk("colon_off",  32'(dif.colon), 32'h0);

    // 09:59 with leading-zero blanking
    set_time(2'd0, 4'd9, 3'd5, 4'd9);
    dif.blank_lead_zero = 1'b1;
    goto_cyc(81); chk("t959_seg0", 32'(dif.seg), 32'h6F);
    goto_cyc(85); chk("t959_seg1", 32'(dif.seg), 32'h6D);
    goto_cyc(89); chk("t959_seg2", 32'(dif.seg), 32'h6F);
    goto_cyc(93); chk("blank_an", 32'(dif.an), 32'h8); chk("blank_seg", 32'(dif.seg), 32'h00);
    dif.blank_lead_zero = 1'b0;
    goto_cyc(94); chk("noblank_an", 32'(dif.an), 32'h8); chk("noblank_seg", 32'(dif.seg), 32'h3F);

    // non-decimal units digit shows a dash
    set_time(2'd0, 4'd9, 3'd5, 4'hC);
    goto_cyc(97); chk("dash_an", 32'(dif.an), 32'h1); chk("dash_seg", 32'(dif.seg), 32'h40);
    chk("colon_on2", 32'(dif.colon), 32'h1);

    // drop enable in the middle of digit 2
    goto_cyc(106); chk("pre_gap_an", 32'(dif.an), 32'h4);
    dif.enable = 1'b0;
    goto_cyc(107);
    chk("gap_an", 32'(dif.an), 32'h0); chk("gap_seg", 32'(dif.seg), 32'h0);
    chk("gap_colon", 32'(dif.colon), 32'h0);
    goto_cyc(116);
    chk("gap_end_an", 32'(dif.an), 32'h0); chk("gap_end_fd", 32'(dif.frame_done), 32'h0);
    dif.enable = 1'b1;
    goto_cyc(117);
    chk("resume_an", 32'(dif.an), 32'h4); chk("resume_seg", 32'(dif.seg), 32'h6F);
    chk("resume_colon", 32'(dif.colon), 32'h1);
    goto_cyc(118); chk("resume_an_last", 32'(dif.an), 32'h4);
    goto_cyc(119); chk("resume_an3", 32'(dif.an), 32'h8); chk("resume_seg3", 32'(dif.seg), 32'h3F);
    goto_cyc(121); chk("resume_fd_low", 32'(dif.frame_done), 32'h0);
    goto_cyc(122); chk("resume_fd", 32'(dif.frame_done), 32'h1);

    // reset in the middle of a frame, then recapture 23:47
    set_time(2'd2, 4'd3, 3'd4, 4'd7);
    goto_cyc(125);
    reset = 1'b0;
    goto_cyc(126);
    chk("mid_rst_an",    32'(dif.an),         32'h0);
    chk("mid_rst_seg",   32'(dif.seg),        32'h0);
    chk("mid_rst_colon", 32'(dif.colon),      32'h0);
    chk("mid_rst_fd",    32'(dif.frame_done), 32'h0);
    reset = 1'b1;
    goto_cyc(127); chk("post_rst_an0", 32'(dif.an), 32'h1);
    goto_cyc(128); chk("post_rst_an", 32'(dif.an), 32'h1); chk("post_rst_seg", 32'(dif.seg), 32'h07);
    goto_cyc(132); chk("post_rst_an1", 32'(dif.an), 32'h2); chk("post_rst_seg1", 32'(dif.seg), 32'h66);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
